// File: rtl/uart_demo_hex.sv
// rtl/uart_demo_hex.sv - UART demo top: RX byte to LEDs, debounced buttons send ASCII-hex report frames
// Optional echo of every received byte when UART_DEMO_ECHO_EN is defined.
module uart_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        cfg_txen,
  input  logic        cfg_rxen,
  input  logic        cfg_nstop,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        txd,
  input  logic        rxd
);
  // one bit period is cfg_div clock cycles; 8N1 framing, one extra stop bit when cfg_nstop=1
  logic [9:0]  tx_shift;
  logic [3:0]  tx_bits;
  logic [15:0] tx_cnt;
  logic        tx_active;
  logic        rxd_s1, rxd_s2;
  logic        rx_active;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bits;
  logic [7:0]  rx_shift;

  assign tx_ready = cfg_txen & ~tx_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_shift  <= '1;
      tx_bits   <= '0;
      tx_cnt    <= '0;
      txd       <= 1'b1;
    end else if (!tx_active) begin
      txd <= 1'b1;
      if (tx_valid && tx_ready) begin
        tx_active <= 1'b1;
        tx_shift  <= {2'b11, tx_data};
        tx_bits   <= 4'd10 + {3'b000, cfg_nstop};
        tx_cnt    <= '0;
        txd       <= 1'b0;
      end
    end else if (tx_cnt == cfg_div - 16'd1) begin
      tx_cnt  <= '0;
      tx_bits <= tx_bits - 4'd1;
      if (tx_bits == 4'd1) begin
        tx_active <= 1'b0;
        txd       <= 1'b1;
      end else begin
        txd      <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[9:1]};
      end
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1    <= 1'b1;
      rxd_s2    <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bits   <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rx_valid <= 1'b0;
      if (!rx_active) begin
        if (cfg_rxen && !rxd_s2) begin
          rx_active <= 1'b1;
          rx_cnt    <= cfg_div >> 1;
          rx_bits   <= '0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= cfg_div - 16'd1;
        if (rx_bits == 4'd0) begin
          if (rxd_s2) rx_active <= 1'b0;
          else        rx_bits   <= 4'd1;
        end else if (rx_bits <= 4'd8) begin
          rx_shift <= {rxd_s2, rx_shift[7:1]};
          rx_bits  <= rx_bits + 4'd1;
        end else begin
          rx_active <= 1'b0;
          if (rxd_s2) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
          end
        end
      end
    end
  end
endmodule

module uart_demo_hex #(
  parameter int BAUDRATE        = 115200,
  parameter int CLK_FREQ        = 100000000,
  parameter int SW_WIDTH        = 8,
  parameter int LED_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NSTOP           = 0
) (
  input  logic                 clk,
  input  logic                 rst_b,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic                 btn0,
  input  logic                 btn1,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy
);
  localparam logic [15:0] DIV = 16'(CLK_FREQ / BAUDRATE + 1);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam int FW = (SW_WIDTH > 8) ? SW_WIDTH : 8;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t              state;
  logic                tx_valid, tx_ready, rx_valid;
  logic [7:0]          tx_data, rx_data, rcvd;
  logic [1:0]          btn_s1, btn_s2, deb, press;
  logic [DCW-1:0]      db_cnt [2];
  logic [SW_WIDTH-1:0] sw_s1, sw_s2;
  logic                pend0, pend1, msg_rx, raw;
  logic [FW-1:0]       frame;
  logic [4:0]          len, idx, nib_sel;
  logic [6:0]          shamt;
  logic [3:0]          nib;
`ifdef UART_DEMO_ECHO_EN
  logic                echo_valid;
  logic [7:0]          echo_byte;
`endif

  uart_core u_core (
    .clk       (clk),
    .rst_n     (rst_b),
    .cfg_div   (DIV),
    .cfg_txen  (1'b1),
    .cfg_rxen  (1'b1),
    .cfg_nstop (NSTOP != 0),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .txd       (uart_txd),
    .rxd       (uart_rxd)
  );

  assign led = rcvd[LED_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      deb       <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      btn_s1 <= {btn1, btn0};
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (btn_s2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= btn_s2[i];
          db_cnt[i] <= '0;
          press[i]  <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // byte[idx] is derived from registers that only move on accept, so it is stable while tx_valid waits
  always_comb begin
    tx_data = 8'h00;
    nib_sel = len - idx - 5'd3;
    shamt   = {nib_sel, 2'b00};
    nib     = 4'(frame >> shamt);
    if (raw)                     tx_data = frame[7:0];
    else if (idx == len - 5'd2)  tx_data = 8'h0D;
    else if (idx == len - 5'd1)  tx_data = 8'h0A;
    else if (nib < 4'd10)        tx_data = {4'h3, nib};
    else                         tx_data = 8'h37 + {4'h0, nib};
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      msg_rx   <= 1'b0;
      raw      <= 1'b0;
      frame    <= '0;
      len      <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      rcvd     <= '0;
`ifdef UART_DEMO_ECHO_EN
      echo_valid <= 1'b0;
      echo_byte  <= '0;
`endif
    end else begin
      pend0 <= pend0 | press[0];
      pend1 <= pend1 | press[1];
      if (rx_valid) rcvd <= rx_data;
`ifdef UART_DEMO_ECHO_EN
      if (rx_valid) begin
        echo_valid <= 1'b1;
        echo_byte  <= rx_data;
      end
`endif
      case (state)
        IDLE: begin
`ifdef UART_DEMO_ECHO_EN
          if (echo_valid) begin
            state      <= SEND;
            busy       <= 1'b1;
            raw        <= 1'b1;
            frame      <= FW'(echo_byte);
            len        <= 5'd1;
            idx        <= '0;
            tx_valid   <= 1'b1;
            echo_valid <= rx_valid;
          end else
`endif
          if (pend0) begin
            state  <= LOAD;
            busy   <= 1'b1;
            msg_rx <= 1'b1;
            pend0  <= press[0];
          end else if (pend1) begin
            state  <= LOAD;
            busy   <= 1'b1;
            msg_rx <= 1'b0;
            pend1  <= press[1];
          end
        end
        LOAD: begin
          frame    <= msg_rx ? FW'(rcvd) : FW'(sw_s2);
          len      <= msg_rx ? 5'd4 : 5'(SW_WIDTH / 4 + 2);
          raw      <= 1'b0;
          idx      <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            idx <= idx + 5'd1;
            if (idx == len - 5'd1) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_demo_hex.sv
// tb/tb_uart_demo_hex.sv - scoreboard bench for uart_demo_hex (serial RX driver, serial TX monitor)
module tb_uart_demo_hex;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUDRATE = 125000;
  localparam int DIV      = CLK_FREQ / BAUDRATE + 1;
`ifdef UART_DEMO_ECHO_EN
  localparam int ECHO_N = 1;
`else
  localparam int ECHO_N = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       btn0 = 1'b0;
  logic       btn1 = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       uart_txd;
  logic [7:0] led;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         tx_count = 0;
  int         base;
  logic [7:0] exp_q [$];

  uart_demo_hex #(
    .BAUDRATE(BAUDRATE), .CLK_FREQ(CLK_FREQ), .SW_WIDTH(8), .LED_WIDTH(8),
    .DEBOUNCE_CYCLES(4), .NSTOP(0)
  ) dut (
    .clk(clk), .rst_b(rst_b), .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .sw(sw), .btn0(btn0), .btn1(btn1), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic push_hex(input logic [7:0] v);
    exp_q.push_back(hex_ch(v[7:4]));
    exp_q.push_back(hex_ch(v[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int budget = 20000;
    while (tx_count < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, tx_count, n);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int start = tx_count;
    if (ECHO_N != 0) exp_q.push_back(b);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (DIV + 3) @(negedge clk);
    if (ECHO_N != 0) wait_tx(start + 1, "echo_byte");
  endtask

  task automatic press(input logic p0, input logic p1);
    @(negedge clk);
    btn0 = p0;
    btn1 = p1;
    repeat (10) @(negedge clk);
    btn0 = 1'b0;
    btn1 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // TX monitor: decodes each frame byte mid-bit and pops the scoreboard
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_b && uart_txd == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        check("tx_start", uart_txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop", uart_txd, 1'b1);
        check("tx_expected_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
        tx_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=finished", tx_count);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_txd", uart_txd, 1'b1);
    rst_b = 1'b1;
    repeat (5) @(negedge clk);

    // 1: RX lands on LEDs, no report frame
    rx_byte(8'hA5);
    check("t1_led", led, 8'hA5);
    check("t1_busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    check("t1_no_tx", tx_count, ECHO_N);

    // 2: RX byte report
    rx_byte(8'h3C);
    base = tx_count;
    push_hex(8'h3C);
    press(1'b1, 1'b0);
    check("t2_busy_high", busy, 1'b1);
    wait_tx(base + 4, "t2_frame");
    check("t2_busy_low", busy, 1'b0);
    repeat (200) @(negedge clk);
    check("t2_single_frame", tx_count, base + 4);

    // 3: switch report keeps its snapshot
    base = tx_count;
    sw = 8'h9F;
    push_hex(8'h9F);
    press(1'b0, 1'b1);
    wait_tx(base + 1, "t3_first");
    sw = 8'h00;
    wait_tx(base + 4, "t3_frame");

    // 4: bouncing button never registers
    base = tx_count;
    for (int i = 0; i < 10; i++) begin
      btn0 = ~btn0;
      repeat (2) @(negedge clk);
    end
    btn0 = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_busy", busy, 1'b0);
    repeat (200) @(negedge clk);
    check("t4_no_tx", tx_count, base);

    // 5: simultaneous presses, extra btn1 presses collapse
    base = tx_count;
    sw = 8'hC7;
    push_hex(8'h3C);
    push_hex(8'hC7);
    press(1'b1, 1'b1);
    wait_tx(base + 1, "t5_start");
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    wait_tx(base + 8, "t5_frames");
    repeat (400) @(negedge clk);
    check("t5_exact_count", tx_count, base + 8);

    // 6: reset mid-frame discards the rest
    base = tx_count;
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h43);
    press(1'b1, 1'b0);
    wait_tx(base + 2, "t6_two_bytes");
    rst_b = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_led", led, 8'h00);
    check("t6_txd", uart_txd, 1'b1);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (600) @(negedge clk);
    check("t6_no_more", tx_count, base + 2);

`ifdef UART_DEMO_ECHO_EN
    rx_byte(8'h41);
    check("echo_led", led, 8'h41);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
